seq_stream_arbiter: RTL and testbench
=====================================

# seq_stream_arbiter

Round-robin arbiter and sequencer that shares a single bit-serial "1011" pattern-detector core among `NUM_REQ` serial requesters. Each granted requester streams a fixed-length frame of `FRAME_LEN` bits. The block clears the detector before each frame, counts pattern matches within the frame, and reports a per-frame result with the winning requester's ID. It sits between the serial stream sources and downstream status logic, and is the owner of the detector core.

## Interface
- `NUM_REQ`, default 4: number of requesters, 2..16.
- `FRAME_LEN`, default 16: bits per frame, 4..255.
- `CNT_W`, default 5: match counter width.
- `clk` input 1: single clock; all state updates on the rising edge.
- `reset` input 1: asynchronous, active-low reset.
- `req` input `NUM_REQ`: per-requester request; must be held high through its frame.
- `bit_in` input `NUM_REQ`: per-requester serial data, sampled only for the granted requester.
- `grant` output `NUM_REQ`: one-hot grant; all zero when no frame is in progress.
- `busy` output 1: high in GRANT and STREAM.
- `done` output 1: one-cycle pulse in REPORT.
- `done_id` output `$clog2(NUM_REQ)`: ID of the frame that just completed.
- `match_cnt` output `CNT_W`: matches counted in the last frame.
- `abort` output 1: qualifies `done`; set when the frame was cut short.

## Operation
- **FSM states:** IDLE, GRANT, STREAM, REPORT.
- **IDLE:**
  - If any `req` bit is high, pick the winner and go to GRANT.
  - Otherwise stay in IDLE.
- **Round-robin arbitration:**
  - Search starts at (last granted ID + 1) mod `NUM_REQ`.
  - The first asserted `req` in that order wins.
  - The pointer resets to `NUM_REQ-1`, so requester 0 has priority after reset.
- **GRANT (1 cycle):**
  - Assert `grant[id]`.
  - Clear the detector core to S0, the bit counter to 0, and `match_cnt` to 0.
  - Go to STREAM.
- **STREAM:**
  - Sample `bit_in[id]` every cycle into the core.
  - Increment the bit counter.
  - After the `FRAME_LEN`-th sample, go to REPORT.
- **Detector core states:** S0, S1 ("1"), S10, S101.
  - Mealy match output: asserted when in S101 and the sampled bit is 1.
  - Each match increments `match_cnt`, saturating at 2^`CNT_W`-1.
- **Abort:** if `req[id]` is low on any STREAM cycle:
  - That bit is not sampled.
  - `abort` latches to 1 and the FSM goes to REPORT.
- **REPORT (1 cycle):**
  - `done`=1, `grant`=0.
  - Update the round-robin pointer to `id`, then go to IDLE.
- **Output hold:** `match_cnt`, `done_id`, and `abort` hold their values from REPORT until the next GRANT.
- **Request changes:**
  - Requests arriving or dropping for non-granted IDs during a frame have no effect.
  - They are re-evaluated in IDLE.
- **Reset mid-frame:** immediately forces IDLE and all outputs to their reset values; the frame is lost and no `done` is issued.

## Timing
- **Reset values:** `grant`=0, `busy`=0, `done`=0, `done_id`=0, `match_cnt`=0, `abort`=0, FSM=IDLE, core=S0.
- **Request to grant:** `req` seen high in IDLE at edge t gives `grant` high during cycle t+1 (GRANT).
- **Data sampling:** the requester presents bit k (k=0..`FRAME_LEN`-1) during STREAM cycle k, and it is sampled at the end of that cycle.
- **Frame latency:** `done` pulses `FRAME_LEN`+2 cycles after the IDLE decision.
- **Frame spacing:** the minimum spacing between consecutive frames is `FRAME_LEN`+3 cycles, because one IDLE cycle always separates REPORT from the next GRANT.
- **Count update:** `match_cnt` increments at the same edge that samples the completing bit. Intermediate values are visible but are only defined as the result at `done`.

## Configuration
- `SEQ_ARB_OVERLAP_EN` defined: overlapping detection. After a match the core goes to S1, so stream 1011011 counts 2.
- `SEQ_ARB_OVERLAP_EN` undefined: non-overlapping detection. After a match the core returns to S0, so stream 1011011 counts 1.

## Structure
- **Shared package `seq_arb_pkg`:**
  - Arbiter FSM state enum (IDLE/GRANT/STREAM/REPORT).
  - Detector state enum (S0/S1/S10/S101).
  - Constant `PATTERN` = 4'b1011.
- **Sub-module `seq_match_core`:**
  - Ports: `clk`, `reset`, `clr`, `en`, `x`, `match`.
  - Contains the 4-state detector and the overlap macro handling.
  - The arbiter instantiates it once.

## Test plan
- **Reset:** assert `reset` low for 2 cycles mid-STREAM, then release. Require: all outputs 0, FSM in IDLE, no `done`.
- **Single requester, `FRAME_LEN`=8:** `req[2]` high, bits 1,0,1,1,0,0,0,0. Require: `grant`=4'b0100 from the cycle after the request, `done` 10 cycles after the IDLE decision, `done_id`=2, `match_cnt`=1, `abort`=0.
- **Overlap, `FRAME_LEN`=8, bits 1,0,1,1,0,1,1,0:**
  - With `SEQ_ARB_OVERLAP_EN` defined: `match_cnt`=2.
  - Without it: `match_cnt`=1.
- **Round robin:** hold `req`=4'b1111 for 4 frames. Require: `done_id` sequence 0,1,2,3, and `grant` is never multi-hot.
- **Abort:** drop `req[1]` on STREAM cycle 3 after bits 1,0,1. Require: `done` on the next cycle with `abort`=1, `match_cnt`=0, `done_id`=1.
- **Saturation:** `CNT_W`=2, `FRAME_LEN`=32, stream all 1011 repeats. Require: `match_cnt`=3 at `done`.

Source files
------------

// File: rtl/seq_stream_arbiter_pkg.sv
// seq_arb_pkg: shared state encodings and the target pattern for the stream arbiter
package seq_arb_pkg;
  typedef enum logic [1:0] {IDLE, GRANT, STREAM, REPORT} arb_state_t;
  typedef enum logic [1:0] {S0, S1, S10, S101} det_state_t;
  localparam logic [3:0] PATTERN = 4'b1011;
endpackage

// File: rtl/seq_match_core.sv
// seq_match_core: bit-serial 1011 Mealy detector; SEQ_ARB_OVERLAP_EN selects overlapping matches
module seq_match_core
  import seq_arb_pkg::*;
(
  input  logic clk,
  input  logic reset,
  input  logic clr,
  input  logic en,
  input  logic x,
  output logic match
);
`ifdef SEQ_ARB_OVERLAP_EN
  localparam det_state_t AFTER_MATCH = S1;
`else
  localparam det_state_t AFTER_MATCH = S0;
`endif
  det_state_t state, state_next;
  always_ff @(posedge clk or negedge reset)
    if (!reset) state <= S0;
    else if (clr) state <= S0;
    else if (en) state <= state_next;
  always_comb begin
    state_next = S0;
    match = en && !clr && state == S101 && x == PATTERN[0];
    unique case (state)
      S0:   state_next = x == PATTERN[3] ? S1 : S0;
      S1:   state_next = x == PATTERN[2] ? S10 : S1;
      S10:  state_next = x == PATTERN[1] ? S101 : S0;
      S101: state_next = x == PATTERN[0] ? AFTER_MATCH : S10;
    endcase
  end
endmodule

// File: rtl/seq_stream_arbiter.sv
// seq_stream_arbiter: round-robin sharing of one 1011 detector among serial requesters (SEQ_ARB_OVERLAP_EN in seq_match_core)
module seq_stream_arbiter
  import seq_arb_pkg::*;
#(
  parameter  int NUM_REQ   = 4,
  parameter  int FRAME_LEN = 16,
  parameter  int CNT_W     = 5,
  localparam int ID_W      = $clog2(NUM_REQ)
) (
  input  logic               clk,
  input  logic               reset,
  input  logic [NUM_REQ-1:0] req,
  input  logic [NUM_REQ-1:0] bit_in,
  output logic [NUM_REQ-1:0] grant,
  output logic               busy,
  output logic               done,
  output logic [ID_W-1:0]    done_id,
  output logic [CNT_W-1:0]   match_cnt,
  output logic               abort
);
  arb_state_t state, state_next;
  logic [ID_W-1:0] id, ptr, win, idx;
  logic [7:0] bit_cnt;
  logic live, sample, hit;
  assign live    = req[id];
  assign sample  = state == STREAM && live;
  assign done_id = id;
  always_comb begin
    win = ptr;
    idx = '0;
    // walk from farthest to nearest so the first requester after ptr wins
    for (int i = NUM_REQ; i > 0; i--) begin
      idx = ID_W'((int'(ptr) + i) % NUM_REQ);
      if (req[idx]) win = idx;
    end
  end
  always_ff @(posedge clk or negedge reset)
    if (!reset) state <= IDLE;
    else state <= state_next;
  always_comb begin
    state_next = state;
    busy = state == GRANT || state == STREAM;
    done = state == REPORT;
    grant = busy ? NUM_REQ'(1) << id : '0;
    case (state)
      IDLE:    state_next = |req ? GRANT : IDLE;
      GRANT:   state_next = STREAM;
      STREAM:  state_next = (!live || bit_cnt == 8'(FRAME_LEN - 1)) ? REPORT : STREAM;
      REPORT:  state_next = IDLE;
      default: state_next = IDLE;
    endcase
  end
  always_ff @(posedge clk or negedge reset)
    if (!reset) begin
      id <= '0;
      ptr <= ID_W'(NUM_REQ - 1);
      bit_cnt <= '0;
      match_cnt <= '0;
      abort <= 1'b0;
    end else begin
      if (state == IDLE && |req) id <= win;
      if (state == GRANT) begin
        bit_cnt <= '0;
        match_cnt <= '0;
        abort <= 1'b0;
      end
      if (sample) begin
        bit_cnt <= bit_cnt + 8'd1;
        if (hit && !(&match_cnt)) match_cnt <= match_cnt + 1'b1;
      end
      if (state == STREAM && !live) abort <= 1'b1;
      if (state == REPORT) ptr <= id;
    end
  seq_match_core u_core (
    .clk   (clk),
    .reset (reset),
    .clr   (state == GRANT),
    .en    (sample),
    .x     (bit_in[id]),
    .match (hit)
  );
endmodule

// File: tb/tb_seq_stream_arbiter.sv
// tb_seq_stream_arbiter: directed checks of arbitration, detection, abort, saturation and reset
module tb_seq_stream_arbiter;
  logic clk = 1'b0, rst_n = 1'b0;
  logic [3:0] req_a = '0, bit_a = '0, req_b = '0, bit_b = '0;
  logic [3:0] grant_a, grant_b;
  logic busy_a, done_a, abort_a, busy_b, done_b, abort_b;
  logic [1:0] done_id_a, done_id_b, mcnt_b;
  logic [4:0] mcnt_a;
  int checks = 0, passed = 0;
  always #5 clk = ~clk;
  seq_stream_arbiter #(.NUM_REQ(4), .FRAME_LEN(8), .CNT_W(5)) dut_a (
    .clk(clk), .reset(rst_n), .req(req_a), .bit_in(bit_a), .grant(grant_a), .busy(busy_a),
    .done(done_a), .done_id(done_id_a), .match_cnt(mcnt_a), .abort(abort_a));
  seq_stream_arbiter #(.NUM_REQ(4), .FRAME_LEN(32), .CNT_W(2)) dut_b (
    .clk(clk), .reset(rst_n), .req(req_b), .bit_in(bit_b), .grant(grant_b), .busy(busy_b),
    .done(done_b), .done_id(done_id_b), .match_cnt(mcnt_b), .abort(abort_b));
  task automatic tick;
    @(posedge clk); #1;
  endtask
  task automatic frame_a(input int r, input logic [7:0] bits, input int drop_at, output int cyc, output logic [3:0] g);
    req_a = 4'b0001 << r;
    tick; cyc = 1; g = grant_a;
    tick; cyc++;
    for (int k = 0; k < 8; k++) begin
      if (k == drop_at) begin req_a[r] = 1'b0; tick; cyc++; break; end
      bit_a[r] = bits[7-k];
      tick; cyc++;
    end
    bit_a = '0;
  endtask
  task automatic test_reset;
    tick; tick;
    checks++; if (grant_a !== 4'b0) $display("FAIL rst_grant got %b want 0000", grant_a); else passed++;
    checks++; if (busy_a !== 1'b0) $display("FAIL rst_busy got %b want 0", busy_a); else passed++;
    checks++; if (done_a !== 1'b0) $display("FAIL rst_done got %b want 0", done_a); else passed++;
    checks++; if (mcnt_a !== 5'd0 || mcnt_b !== 2'd0) $display("FAIL rst_mcnt got %0d/%0d want 0/0", mcnt_a, mcnt_b); else passed++;
    checks++; if (done_id_a !== 2'd0 || abort_a !== 1'b0) $display("FAIL rst_id_abort got %0d/%b want 0/0", done_id_a, abort_a); else passed++;
    rst_n = 1'b1;
    tick;
  endtask
  task automatic test_round_robin;
    logic multi = 1'b0;
    int n;
    req_a = 4'b1111;
    for (int f = 0; f < 4; f++) begin
      n = 0;
      tick;
      while (!done_a && n < 20) begin
        if (!$onehot0(grant_a)) multi = 1'b1;
        tick; n++;
      end
      checks++; if (done_a !== 1'b1) $display("FAIL rr_timeout frame %0d got done=%b want 1", f, done_a); else passed++;
      checks++; if (done_id_a !== 2'(f)) $display("FAIL rr_id frame %0d got %0d want %0d", f, done_id_a, f); else passed++;
    end
    req_a = '0;
    tick; tick;
    checks++; if (multi !== 1'b0) $display("FAIL rr_onehot got multi-hot=%b want 0", multi); else passed++;
  endtask
  task automatic test_single;
    int cyc; logic [3:0] g;
    frame_a(2, 8'b1011_0000, 99, cyc, g);
    checks++; if (g !== 4'b0100) $display("FAIL single_grant got %b want 0100", g); else passed++;
    checks++; if (done_a !== 1'b1 || cyc != 10) $display("FAIL single_latency got done=%b cyc=%0d want 1 10", done_a, cyc); else passed++;
    checks++; if (done_id_a !== 2'd2) $display("FAIL single_id got %0d want 2", done_id_a); else passed++;
    checks++; if (mcnt_a !== 5'd1) $display("FAIL single_mcnt got %0d want 1", mcnt_a); else passed++;
    checks++; if (abort_a !== 1'b0 || grant_a !== 4'b0) $display("FAIL single_abort_grant got %b/%b want 0/0000", abort_a, grant_a); else passed++;
    req_a = '0;
    tick;
    checks++; if (done_a !== 1'b0 || mcnt_a !== 5'd1 || done_id_a !== 2'd2) $display("FAIL single_hold got %b/%0d/%0d want 0/1/2", done_a, mcnt_a, done_id_a); else passed++;
  endtask
  task automatic test_overlap;
    int cyc; logic [3:0] g;
    logic [4:0] exp;
`ifdef SEQ_ARB_OVERLAP_EN
    exp = 5'd2;
`else
    exp = 5'd1;
`endif
    frame_a(0, 8'b1011_0110, 99, cyc, g);
    checks++; if (done_a !== 1'b1 || mcnt_a !== exp) $display("FAIL overlap_mcnt got done=%b cnt=%0d want 1 %0d", done_a, mcnt_a, exp); else passed++;
    req_a = '0;
    tick;
  endtask
  task automatic test_abort;
    int cyc; logic [3:0] g;
    frame_a(1, 8'b1010_0000, 3, cyc, g);
    checks++; if (done_a !== 1'b1 || cyc != 6) $display("FAIL abort_done got done=%b cyc=%0d want 1 6", done_a, cyc); else passed++;
    checks++; if (abort_a !== 1'b1) $display("FAIL abort_flag got %b want 1", abort_a); else passed++;
    checks++; if (mcnt_a !== 5'd0 || done_id_a !== 2'd1) $display("FAIL abort_cnt_id got %0d/%0d want 0/1", mcnt_a, done_id_a); else passed++;
    tick;
  endtask
  task automatic test_reset_mid;
    logic seen = 1'b0;
    req_a = 4'b0100;
    tick; tick;
    bit_a[2] = 1'b1; tick;
    bit_a[2] = 1'b0; tick;
    bit_a[2] = 1'b1; tick;
    bit_a[2] = 1'b1; tick;
    checks++; if (busy_a !== 1'b1 || mcnt_a !== 5'd1 || done_id_a !== 2'd2) $display("FAIL mid_pre got %b/%0d/%0d want 1/1/2", busy_a, mcnt_a, done_id_a); else passed++;
    rst_n = 1'b0;
    #1;
    checks++; if (grant_a !== 4'b0 || busy_a !== 1'b0) $display("FAIL mid_grant_busy got %b/%b want 0000/0", grant_a, busy_a); else passed++;
    checks++; if (mcnt_a !== 5'd0 || done_id_a !== 2'd0 || abort_a !== 1'b0) $display("FAIL mid_outs got %0d/%0d/%b want 0/0/0", mcnt_a, done_id_a, abort_a); else passed++;
    tick; tick;
    req_a = '0; bit_a = '0;
    rst_n = 1'b1;
    for (int i = 0; i < 12; i++) begin
      if (done_a || busy_a) seen = 1'b1;
      tick;
    end
    checks++; if (seen !== 1'b0) $display("FAIL mid_no_done got activity=%b want 0", seen); else passed++;
  endtask
  task automatic test_saturation;
    logic [31:0] bits = 32'hBBBB_BBBB;
    req_b = 4'b0001;
    tick;
    checks++; if (grant_b !== 4'b0001) $display("FAIL sat_grant got %b want 0001", grant_b); else passed++;
    tick;
    for (int k = 0; k < 32; k++) begin
      bit_b[0] = bits[31-k];
      tick;
      if (k == 7) begin
        checks++; if (mcnt_b !== 2'd2) $display("FAIL sat_mid got %0d want 2", mcnt_b); else passed++;
      end
    end
    checks++; if (done_b !== 1'b1 || mcnt_b !== 2'd3) $display("FAIL sat_final got done=%b cnt=%0d want 1 3", done_b, mcnt_b); else passed++;
    checks++; if (abort_b !== 1'b0 || done_id_b !== 2'd0) $display("FAIL sat_abort_id got %b/%0d want 0/0", abort_b, done_id_b); else passed++;
    req_b = '0; bit_b = '0;
    tick;
  endtask
  initial begin
    test_reset;
    test_round_robin;
    test_single;
    test_overlap;
    test_abort;
    test_reset_mid;
    test_saturation;
    $display("%0d/%0d checks passed", passed, checks);
    $finish;
  end
endmodule
